// File: rtl/razor_pkg.sv
// Shared Razor definitions: recovery FSM state encoding and pipeline stage indices.
// The pipeline registers use the same stage constants.
package razor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FATAL    = 2'd3
  } razor_state_e;

  localparam int STG_IF_ID  = 0;
  localparam int STG_ID_EX  = 1;
  localparam int STG_EX_MEM = 2;
  localparam int STG_MEM_WR = 3;

endpackage

// File: rtl/razor_recovery_ctrl_if.sv
// Bundle between the Razor pipeline registers/PC logic (master) and the recovery
// controller (slave), plus the controller state for observation.
interface razor_recovery_ctrl_if
  import razor_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 16
);

  // No valid/ready pair: stage_error is a level sampled only while the controller
  // is IDLE, pc_redirect is a single-cycle strobe the PC register must always accept.
  logic [NUM_STAGES-1:0]          stage_error;
  logic [NUM_STAGES*PC_WIDTH-1:0] stage_pc;
  logic                           retire_valid;
  logic                           flush;
  logic                           stall;
  logic                           pc_redirect;
  logic [PC_WIDTH-1:0]            pc_redirect_val;
  logic [CNT_WIDTH-1:0]           error_count;
  logic                           fatal;
  razor_state_e                   state;

  modport master (
    output stage_error, stage_pc, retire_valid,
    input  flush, stall, pc_redirect, pc_redirect_val, error_count, fatal, state
  );

  modport slave (
    input  stage_error, stage_pc, retire_valid,
    output flush, stall, pc_redirect, pc_redirect_val, error_count, fatal, state
  );

endinterface

// File: rtl/razor_recovery_ctrl_oldest_sel.sv
// Picks the oldest (highest-index) stage reporting an error and muxes out its PC.
module razor_oldest_sel #(
  parameter int NUM_STAGES = 4,
  parameter int PC_WIDTH   = 32
) (
  input  logic [NUM_STAGES-1:0]          stage_error,
  input  logic [NUM_STAGES*PC_WIDTH-1:0] stage_pc,
  output logic                           any_err,
  output logic [PC_WIDTH-1:0]            sel_pc
);

  always_comb begin
    any_err = |stage_error;
    sel_pc  = '0;
    // Ascending scan: the last set bit, i.e. the oldest stage, wins.
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_error[i]) sel_pc = stage_pc[i*PC_WIDTH +: PC_WIDTH];
    end
  end

endmodule

// File: rtl/razor_recovery_ctrl.sv
// Razor error-recovery controller: flushes the pipeline, stalls fetch, replays the
// oldest faulting PC, counts errors and goes fatal on replays that never retire.
module razor_recovery_ctrl
  import razor_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int PC_WIDTH     = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic clk,
  input  logic reset,
  razor_recovery_ctrl_if.slave bus
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int RT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic                any_err;
  logic [PC_WIDTH-1:0] sel_pc;

  razor_state_e        state_q;
  logic [FC_W-1:0]     fcnt_q;
  logic [RT_W-1:0]     retry_q;
  logic [PC_WIDTH-1:0] cap_pc_q;
  logic                flush_q;
  logic                stall_q;
  logic                redirect_q;
  logic [PC_WIDTH-1:0] redirect_val_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                fatal_q;

  razor_oldest_sel #(
    .NUM_STAGES (NUM_STAGES),
    .PC_WIDTH   (PC_WIDTH)
  ) u_sel (
    .stage_error (bus.stage_error),
    .stage_pc    (bus.stage_pc),
    .any_err     (any_err),
    .sel_pc      (sel_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      fcnt_q         <= '0;
      retry_q        <= '0;
      cap_pc_q       <= '0;
      flush_q        <= 1'b0;
      stall_q        <= 1'b0;
      redirect_q     <= 1'b0;
      redirect_val_q <= '0;
      count_q        <= '0;
      fatal_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          flush_q    <= 1'b0;
          stall_q    <= 1'b0;
          redirect_q <= 1'b0;
          if (any_err) begin
            cap_pc_q <= sel_pc;
            if (count_q != '1) count_q <= count_q + CNT_WIDTH'(1);
            flush_q <= 1'b1;
            stall_q <= 1'b1;
            if (retry_q == RT_W'(MAX_RETRY)) begin
              fatal_q <= 1'b1;
              state_q <= ST_FATAL;
            end else begin
              retry_q <= retry_q + RT_W'(1);
              fcnt_q  <= FC_W'(FLUSH_CYCLES - 1);
              state_q <= ST_FLUSH;
            end
          end else if (bus.retire_valid) begin
            retry_q <= '0;
          end
        end
        ST_FLUSH: begin
          if (fcnt_q == '0) begin
            flush_q        <= 1'b0;
            redirect_q     <= 1'b1;
            redirect_val_q <= cap_pc_q;
            state_q        <= ST_REDIRECT;
          end else begin
            fcnt_q <= fcnt_q - FC_W'(1);
          end
        end
        ST_REDIRECT: begin
          stall_q    <= 1'b0;
          redirect_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
        ST_FATAL: begin
          // Sticky until reset: keep the pipeline flushed and fetch frozen.
          flush_q    <= 1'b1;
          stall_q    <= 1'b1;
          redirect_q <= 1'b0;
          fatal_q    <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.flush           = flush_q;
  assign bus.stall           = stall_q;
  assign bus.pc_redirect     = redirect_q;
  assign bus.pc_redirect_val = redirect_val_q;
  assign bus.error_count     = count_q;
  assign bus.fatal           = fatal_q;
  assign bus.state           = state_q;

endmodule

// File: tb/tb_razor_recovery_ctrl.sv
// Bench for razor_recovery_ctrl: directed recovery scenarios followed by random
// error/retire traffic, checked against a behavioural model via an expected queue.
module tb_razor_recovery_ctrl;
  import razor_pkg::*;

  localparam int NS      = 4;
  localparam int PW      = 32;
  localparam int FC      = 3;
  localparam int MR      = 3;
  localparam int CW      = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  razor_recovery_ctrl_if #(.NUM_STAGES(NS), .PC_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

  razor_recovery_ctrl #(
    .NUM_STAGES   (NS),
    .PC_WIDTH     (PW),
    .FLUSH_CYCLES (FC),
    .MAX_RETRY    (MR),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [PW+CW-1:0] exp_q[$];
  logic [PW-1:0]    pc_tab[NS];
  int m_retry = 0;
  int m_count = 0;
  int flush_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Oldest faulting stage = highest set index.
  function automatic logic [PW-1:0] oldest_pc(input logic [NS-1:0] err);
    logic [PW-1:0] pc;
    bit found;
    pc = '0;
    found = 0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (!found && err[i]) begin
        pc = pc_tab[i];
        found = 1;
      end
    end
    return pc;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_pcs();
    for (int i = 0; i < NS; i++) bus.stage_pc[i*PW +: PW] = pc_tab[i];
  endtask

  task automatic rand_pcs();
    for (int i = 0; i < NS; i++) pc_tab[i] = $urandom() & 32'hffff_fffc;
  endtask

  task automatic drive_garbage();
    rand_pcs();
    apply_pcs();
    bus.stage_error  = NS'($urandom_range(0, (1 << NS) - 1));
    bus.retire_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flush"},       bus.flush, 0);
    check({tag, "_stall"},       bus.stall, 0);
    check({tag, "_redirect"},    bus.pc_redirect, 0);
    check({tag, "_redirect_val"}, bus.pc_redirect_val, 0);
    check({tag, "_count"},       bus.error_count, 0);
    check({tag, "_fatal"},       bus.fatal, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.stage_error  = '0;
    bus.retire_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_outputs("reset");
    m_retry = 0;
    m_count = 0;
  endtask

  // ret_mode: 0 never retire, 1 always retire, 2 random
  task automatic drive_idle(input int n, input int ret_mode);
    for (int i = 0; i < n; i++) begin
      bit r;
      r = (ret_mode == 2) ? 1'($urandom_range(0, 1)) : (ret_mode == 1);
      rand_pcs();
      apply_pcs();
      bus.stage_error  = '0;
      bus.retire_valid = r;
      tick();
      if (r) m_retry = 0;
    end
  endtask

  // Issue one error in IDLE using pc_tab; the model decides replay vs fatal.
  task automatic drive_error(input logic [NS-1:0] err, input bit ret, input bit rst_mid);
    logic [PW-1:0] epc;
    bit fatal_exp;
    epc = oldest_pc(err);
    if (m_count < CNT_MAX) m_count++;
    fatal_exp = (m_retry == MR);
    if (!fatal_exp) m_retry++;
    apply_pcs();
    bus.stage_error  = err;
    bus.retire_valid = ret;
    if (!fatal_exp && !rst_mid) exp_q.push_back({epc, CW'(m_count)});
    tick();
    if (fatal_exp) begin
      for (int i = 0; i < 3; i++) begin
        drive_garbage();
        tick();
      end
      check("fatal_flag",  bus.fatal, 1);
      check("fatal_flush", bus.flush, 1);
      check("fatal_stall", bus.stall, 1);
      check("fatal_noredirect", bus.pc_redirect, 0);
      check("fatal_count", bus.error_count, m_count);
      do_reset();
    end else if (rst_mid) begin
      drive_garbage();
      tick();
      check("midflush_flush", bus.flush, 1);
      reset = 1'b1;
      bus.stage_error  = '0;
      bus.retire_valid = 1'b0;
      tick();
      reset = 1'b0;
      check_reset_outputs("midreset");
      m_retry = 0;
      m_count = 0;
    end else begin
      for (int i = 0; i < FC + 1; i++) begin
        drive_garbage();
        tick();
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [PW+CW-1:0] e;
    if (!reset && bus.pc_redirect) begin
      check("redirect_flush_len", 64'(flush_run), FC);
      check("redirect_flush_low", bus.flush, 0);
      check("redirect_stall", bus.stall, 1);
      check("redirect_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("redirect_pc", bus.pc_redirect_val, e[PW+CW-1:CW]);
        check("redirect_count", bus.error_count, e[CW-1:0]);
        check("redirect_fatal", bus.fatal, 0);
      end
    end
    if (bus.flush) flush_run++;
    else flush_run = 0;
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.stage_error  = '0;
    bus.stage_pc     = '0;
    bus.retire_valid = 1'b0;
    do_reset();

    // Single MEM_WR error
    rand_pcs();
    pc_tab[STG_MEM_WR] = 32'h40;
    drive_error(4'b1000, 0, 0);
    drive_idle(1, 1);

    // Two stages in error: oldest wins
    rand_pcs();
    pc_tab[STG_ID_EX]  = 32'h48;
    pc_tab[STG_MEM_WR] = 32'h40;
    drive_error(4'b1010, 0, 0);
    drive_idle(2, 0);

    // Four errors without retirement: three replays, then fatal
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rand_pcs();
      drive_error(NS'($urandom_range(1, (1 << NS) - 1)), 0, 0);
      if (i < 3) drive_idle(1, 0);
    end

    // Alternate error and retire: six replays, no fatal
    for (int i = 0; i < 6; i++) begin
      rand_pcs();
      drive_error(NS'($urandom_range(1, (1 << NS) - 1)), 0, 0);
      drive_idle(1, 1);
    end
    check("alt_count", bus.error_count, 6);
    check("alt_fatal", bus.fatal, 0);

    // Error and retire in the same cycle still consume a retry
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rand_pcs();
      drive_error(NS'($urandom_range(1, (1 << NS) - 1)), 1, 0);
      if (i < 3) drive_idle(1, 0);
    end

    // Reset during the second flush cycle
    rand_pcs();
    drive_error(4'b0100, 0, 1);
    drive_idle(FC + 3, 0);

    // Counter saturation
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      rand_pcs();
      drive_error(NS'($urandom_range(1, (1 << NS) - 1)), 0, 0);
      drive_idle(1, 1);
    end
    check("sat_count", bus.error_count, CNT_MAX);

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      drive_idle($urandom_range(0, 3), 2);
      rand_pcs();
      drive_error(NS'($urandom_range(1, (1 << NS) - 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0));
    end

    drive_idle(FC + 3, 0);
    check("queue_drained", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
